// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into STAGES slices,
// each slice a GROUP-bit block CLA, with the inter-slice carry registered.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] operA,
  input  logic [WIDTH-1:0] operB,
  input  logic             Cin,
  input  logic             sub,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] resultOUT,
  output logic             Cout,
  output logic             ovf
);

  localparam int S  = WIDTH / STAGES;
  localparam int NG = S / GROUP;

  // Returns {carry_out, sum}; carries are looked ahead within each group and
  // the group carry is forwarded to the next group.
  function automatic logic [S:0] cla_slice(input logic [S-1:0] a,
                                           input logic [S-1:0] b,
                                           input logic         cin);
    logic [S-1:0] g, p, c;
    logic         cg, gg, pp;
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    cg = cin;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        c[j*GROUP+i] = gg | (pp & cg);
        gg           = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        pp           = pp & p[j*GROUP+i];
      end
      cg = gg | (pp & cg);
    end
    return {cg, p ^ c};
  endfunction

  logic [STAGES-1:0] vld_q, vld_d, adv;

  // A stage moves when it is empty or its successor moves; the last stage moves on outReady.
  always_comb begin
    adv      = '0;
    vld_d    = '0;
    vld_d[0] = inValid;
    for (int k = 1; k < STAGES; k++) vld_d[k] = vld_q[k-1];
    adv[STAGES-1] = !vld_q[STAGES-1] || outReady;
    for (int k = STAGES - 2; k >= 0; k--) adv[k] = !vld_q[k] || adv[k+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= (vld_q & ~adv) | (vld_d & adv);
  end

  assign inReady = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - (k + 1) * S;

    logic [S-1:0]         a_s, b_s;
    logic                 c_s, load;
    logic [S:0]           res;
    logic [(k+1)*S-1:0]   sum_d, sum_q;
    logic                 carry_q;

    assign load = adv[k] && vld_d[k];
    assign res  = cla_slice(a_s, b_s, c_s);

    // Stage 0 takes its slice straight from the ports; B is inverted here for subtract.
    if (k == 0) begin : g_src
      assign a_s   = operA[S-1:0];
      assign b_s   = sub ? ~operB[S-1:0] : operB[S-1:0];
      assign c_s   = sub | Cin;
      assign sum_d = res[S-1:0];
    end else begin : g_src
      assign a_s   = g_stage[k-1].g_fwd.a_q[S-1:0];
      assign b_s   = g_stage[k-1].g_fwd.b_q[S-1:0];
      assign c_s   = g_stage[k-1].carry_q;
      assign sum_d = {res[S-1:0], g_stage[k-1].sum_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (load) begin
        sum_q   <= sum_d;
        carry_q <= res[S];
      end
    end

    // Operand bits not yet consumed are skewed forward to meet their carry.
    if (REM > 0) begin : g_fwd
      logic [REM-1:0] a_d, b_d, a_q, b_q;
      if (k == 0) begin : g_op
        assign a_d = operA[WIDTH-1:S];
        assign b_d = sub ? ~operB[WIDTH-1:S] : operB[WIDTH-1:S];
      end else begin : g_op
        assign a_d = g_stage[k-1].g_fwd.a_q[REM+S-1:S];
        assign b_d = g_stage[k-1].g_fwd.b_q[REM+S-1:S];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // Carry into the MSB is recovered as a^b^sum at that bit.
    if (k == STAGES - 1) begin : g_last
      logic ovf_d, ovf_q;
      assign ovf_d = (a_s[S-1] ^ b_s[S-1] ^ res[S-1]) ^ res[S];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    ovf_q <= 1'b0;
        else if (load) ovf_q <= ovf_d;
      end
    end
  end

  assign outValid  = vld_q[STAGES-1];
  assign resultOUT = g_stage[STAGES-1].sum_q;
  assign Cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed scenarios on a 32/2/4 instance
// plus a random sweep over four other parameter sets.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inValid = 1'b0, Cin = 1'b0, sub = 1'b0, outReady = 1'b0;
  logic        inReady, outValid, Cout, ovf;
  logic [31:0] operA = '0, operB = '0, resultOUT;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .STAGES(2), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .operA(operA), .operB(operB), .Cin(Cin), .sub(sub),
    .outValid(outValid), .outReady(outReady), .resultOUT(resultOUT),
    .Cout(Cout), .ovf(ovf)
  );

  // Sweep instances: 0=(32,1,4) 1=(32,4,4) 2=(64,4,8) 3=(16,2,2)
  logic [3:0]  sw_v = '0, sw_or = '0, sw_c = '0, sw_s = '0;
  logic [3:0]  sw_ir, sw_ov, sw_co, sw_of;
  logic [63:0] sw_a [4];
  logic [63:0] sw_b [4];
  logic [63:0] sw_r [4];
  logic [31:0] r0, r1;
  logic [63:0] r2;
  logic [15:0] r3;

  cla_pipe_adder #(.WIDTH(32), .STAGES(1), .GROUP(4)) u_sw0 (
    .clk(clk), .rst_n(rst_n), .inValid(sw_v[0]), .inReady(sw_ir[0]),
    .operA(sw_a[0][31:0]), .operB(sw_b[0][31:0]), .Cin(sw_c[0]), .sub(sw_s[0]),
    .outValid(sw_ov[0]), .outReady(sw_or[0]), .resultOUT(r0), .Cout(sw_co[0]), .ovf(sw_of[0]));
  cla_pipe_adder #(.WIDTH(32), .STAGES(4), .GROUP(4)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .inValid(sw_v[1]), .inReady(sw_ir[1]),
    .operA(sw_a[1][31:0]), .operB(sw_b[1][31:0]), .Cin(sw_c[1]), .sub(sw_s[1]),
    .outValid(sw_ov[1]), .outReady(sw_or[1]), .resultOUT(r1), .Cout(sw_co[1]), .ovf(sw_of[1]));
  cla_pipe_adder #(.WIDTH(64), .STAGES(4), .GROUP(8)) u_sw2 (
    .clk(clk), .rst_n(rst_n), .inValid(sw_v[2]), .inReady(sw_ir[2]),
    .operA(sw_a[2]), .operB(sw_b[2]), .Cin(sw_c[2]), .sub(sw_s[2]),
    .outValid(sw_ov[2]), .outReady(sw_or[2]), .resultOUT(r2), .Cout(sw_co[2]), .ovf(sw_of[2]));
  cla_pipe_adder #(.WIDTH(16), .STAGES(2), .GROUP(2)) u_sw3 (
    .clk(clk), .rst_n(rst_n), .inValid(sw_v[3]), .inReady(sw_ir[3]),
    .operA(sw_a[3][15:0]), .operB(sw_b[3][15:0]), .Cin(sw_c[3]), .sub(sw_s[3]),
    .outValid(sw_ov[3]), .outReady(sw_or[3]), .resultOUT(r3), .Cout(sw_co[3]), .ovf(sw_of[3]));

  always_comb begin
    sw_r[0] = {32'h0, r0};
    sw_r[1] = {32'h0, r1};
    sw_r[2] = r2;
    sw_r[3] = {48'h0, r3};
  end

  typedef struct packed {
    logic        o;
    logic        c;
    logic [31:0] r;
  } exp_t;

  exp_t        scb [$];
  logic [65:0] swq [4][$];
  int          pass_cnt = 0, total_cnt = 0, cyc_n = 0;
  logic        in_x, out_x, o_v, o_c, o_o, in_rdy;
  logic [31:0] o_r;

  // Reference: returns {ovf, cout, result} for a w-bit add/subtract.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic ci, input logic sb_);
    logic [63:0] mask, res;
    logic [64:0] bb, full;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb   = sb_ ? {1'b0, ~b & mask} : {1'b0, b & mask};
    full = {1'b0, a & mask} + bb + {64'd0, (sb_ ? 1'b1 : ci)};
    co   = full[w];
    res  = full[63:0] & mask;
    ov   = (a[w-1] == bb[w-1]) && (res[w-1] != a[w-1]);
    return {ov, co, res};
  endfunction

  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb_);
    logic [65:0] m;
    m = model(32, {32'h0, a}, {32'h0, b}, ci, sb_);
    return exp_t'({m[65], m[64], m[31:0]});
  endfunction

  function automatic int sw_w(input int i);
    case (i)
      0, 1:    return 32;
      2:       return 64;
      default: return 16;
    endcase
  endfunction

  // One clock of stimulus on the main DUT; records what the coming edge will transfer.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic sb_, input logic ordy);
    @(negedge clk);
    inValid = v; operA = a; operB = b; Cin = ci; sub = sb_; outReady = ordy;
    #1;
    in_x   = inValid && inReady;
    out_x  = outValid && outReady;
    o_v    = outValid;
    o_r    = resultOUT;
    o_c    = Cout;
    o_o    = ovf;
    in_rdy = inReady;
    cyc_n++;
  endtask

  // Single operation into an idle pipeline; reports latency and the result.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic sb_, output int lat, output exp_t got);
    cyc(1'b1, a, b, ci, sb_, 1'b1);
    lat = 0;
    do begin
      cyc(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      lat++;
    end while (!out_x && lat < 10);
    got = exp_t'({o_o, o_c, o_r});
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    total_cnt++; if (outValid !== 1'b0) $display("FAIL reset_outValid: got %b expected 0", outValid); else pass_cnt++;
    total_cnt++; if (resultOUT !== 32'h0) $display("FAIL reset_result: got %h expected 0", resultOUT); else pass_cnt++;
    total_cnt++; if (Cout !== 1'b0) $display("FAIL reset_Cout: got %b expected 0", Cout); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (inReady !== 1'b1) $display("FAIL reset_inReady: got %b expected 1", inReady); else pass_cnt++;
  endtask

  task automatic test_add();
    logic [31:0] ta [2];
    exp_t        te [2];
    int          lat;
    exp_t        got;
    ta = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    te = '{exp_t'({1'b0, 1'b1, 32'h0000_0000}), exp_t'({1'b1, 1'b0, 32'h8000_0000})};
    for (int i = 0; i < 2; i++) begin
      run_one(ta[i], 32'h1, 1'b0, 1'b0, lat, got);
      total_cnt++; if (lat != 2) $display("FAIL add_latency[%0d]: got %0d expected 2", i, lat); else pass_cnt++;
      total_cnt++; if (got.r !== te[i].r) $display("FAIL add_result[%0d]: got %h expected %h", i, got.r, te[i].r); else pass_cnt++;
      total_cnt++; if (got.c !== te[i].c) $display("FAIL add_Cout[%0d]: got %b expected %b", i, got.c, te[i].c); else pass_cnt++;
      total_cnt++; if (got.o !== te[i].o) $display("FAIL add_ovf[%0d]: got %b expected %b", i, got.o, te[i].o); else pass_cnt++;
    end
  endtask

  task automatic test_sub();
    logic [31:0] ta [2];
    logic [31:0] tb [2];
    exp_t        te [2];
    int          lat;
    exp_t        got;
    ta = '{32'h0000_0005, 32'h8000_0000};
    tb = '{32'h0000_0007, 32'h0000_0001};
    te = '{exp_t'({1'b0, 1'b0, 32'hFFFF_FFFE}), exp_t'({1'b1, 1'b1, 32'h7FFF_FFFF})};
    for (int i = 0; i < 2; i++) begin
      run_one(ta[i], tb[i], 1'b1, 1'b1, lat, got);
      total_cnt++; if (lat != 2) $display("FAIL sub_latency[%0d]: got %0d expected 2", i, lat); else pass_cnt++;
      total_cnt++; if (got !== te[i]) $display("FAIL sub_result[%0d]: got %h expected %h", i, got, te[i]); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba [4];
    logic [31:0] bb [4];
    logic        bc [4];
    exp_t        be [4];
    exp_t        e;
    int          i, n_out, last_c;
    ba = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h1234_5678};
    bb = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h5555_5555, 32'h8765_4321};
    bc = '{1'b0, 1'b1, 1'b0, 1'b0};
    be = '{exp_t'({1'b0, 1'b0, 32'h0001_0000}), exp_t'({1'b0, 1'b1, 32'hFFFF_FFFF}),
           exp_t'({1'b0, 1'b0, 32'hFFFF_FFFF}), exp_t'({1'b0, 1'b0, 32'h9999_9999})};
    i = 0; n_out = 0; last_c = 0;
    for (int t = 0; t < 20 && (i < 4 || scb.size() > 0); t++) begin
      if (i < 4) cyc(1'b1, ba[i], bb[i], bc[i], 1'b0, 1'b1);
      else       cyc(1'b0, $urandom, $urandom, 1'b1, 1'b1, 1'b1);
      if (out_x) begin
        total_cnt++;
        if (scb.size() == 0) $display("FAIL b2b_underflow: got unexpected result %h", o_r);
        else begin
          e = scb.pop_front();
          if ({o_o, o_c, o_r} !== e) $display("FAIL b2b_result[%0d]: got %h expected %h", n_out, {o_o, o_c, o_r}, e);
          else pass_cnt++;
        end
        if (n_out > 0) begin
          total_cnt++;
          if (cyc_n != last_c + 1) $display("FAIL b2b_consecutive[%0d]: got gap %0d expected 1", n_out, cyc_n - last_c);
          else pass_cnt++;
        end
        last_c = cyc_n;
        n_out++;
      end
      if (in_x) begin
        scb.push_back(be[i]);
        i++;
      end
    end
    total_cnt++; if (n_out != 4) $display("FAIL b2b_count: got %0d expected 4", n_out); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    exp_t        held, e;
    int          idx, acc, n;
    logic        seen, bad;
    for (int k = 0; k < 4; k++) begin
      pa[k] = $urandom;
      pb[k] = $urandom;
    end
    idx = 0; acc = 0; seen = 1'b0; bad = 1'b0; held = '0;
    for (int k = 0; k < 5; k++) begin
      if (idx < 4) cyc(1'b1, pa[idx], pb[idx], 1'b0, 1'b0, 1'b0);
      else         cyc(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
      if (o_v) begin
        if (!seen) begin
          held = exp_t'({o_o, o_c, o_r});
          seen = 1'b1;
        end else if ({o_o, o_c, o_r} !== held) bad = 1'b1;
      end
      if (in_x) begin
        scb.push_back(model32(pa[idx], pb[idx], 1'b0, 1'b0));
        idx++;
        acc++;
      end
    end
    total_cnt++; if (acc != 2) $display("FAIL bp_accepted: got %0d expected 2", acc); else pass_cnt++;
    total_cnt++; if (in_rdy !== 1'b0) $display("FAIL bp_inReady: got %b expected 0", in_rdy); else pass_cnt++;
    total_cnt++; if (seen !== 1'b1) $display("FAIL bp_outValid: got %b expected 1", seen); else pass_cnt++;
    total_cnt++; if (held !== scb[0]) $display("FAIL bp_held_value: got %h expected %h", held, scb[0]); else pass_cnt++;
    total_cnt++; if (bad !== 1'b0) $display("FAIL bp_hold_stable: got %b expected 0", bad); else pass_cnt++;
    n = 0;
    for (int t = 0; t < 40 && (idx < 4 || scb.size() > 0); t++) begin
      if (idx < 4) cyc(1'b1, pa[idx], pb[idx], 1'b0, 1'b0, 1'b1);
      else         cyc(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      if (out_x) begin
        total_cnt++;
        if (scb.size() == 0) $display("FAIL bp_underflow: got unexpected result %h", o_r);
        else begin
          e = scb.pop_front();
          if ({o_o, o_c, o_r} !== e) $display("FAIL bp_result[%0d]: got %h expected %h", n, {o_o, o_c, o_r}, e);
          else pass_cnt++;
        end
        n++;
      end
      if (in_x) begin
        scb.push_back(model32(pa[idx], pb[idx], 1'b0, 1'b0));
        idx++;
      end
    end
    total_cnt++; if (n != 4) $display("FAIL bp_count: got %0d expected 4", n); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    int stale;
    cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    total_cnt++; if (o_v !== 1'b1) $display("FAIL mid_pre_outValid: got %b expected 1", o_v); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (outValid !== 1'b0) $display("FAIL mid_outValid: got %b expected 0", outValid); else pass_cnt++;
    total_cnt++; if (resultOUT !== 32'h0) $display("FAIL mid_result: got %h expected 0", resultOUT); else pass_cnt++;
    total_cnt++; if ({Cout, ovf} !== 2'b00) $display("FAIL mid_flags: got %b expected 00", {Cout, ovf}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (inReady !== 1'b1) $display("FAIL mid_inReady: got %b expected 1", inReady); else pass_cnt++;
    stale = 0;
    for (int t = 0; t < 8; t++) begin
      cyc(1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      if (o_v) stale++;
    end
    total_cnt++; if (stale != 0) $display("FAIL mid_stale: got %0d results expected 0", stale); else pass_cnt++;
    scb.delete();
  endtask

  task automatic test_sweep();
    logic [65:0] e;
    for (int t = 0; t < 14000; t++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (t < 13800) begin
          sw_v[i]  = ($urandom_range(0, 3) != 0);
          sw_or[i] = ($urandom_range(0, 3) != 0);
        end else begin
          sw_v[i]  = 1'b0;
          sw_or[i] = 1'b1;
        end
        sw_a[i] = {$urandom, $urandom};
        sw_b[i] = {$urandom, $urandom};
        sw_c[i] = 1'($urandom);
        sw_s[i] = 1'($urandom);
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (sw_ov[i] && sw_or[i]) begin
          total_cnt++;
          if (swq[i].size() == 0) $display("FAIL sweep_underflow[%0d]: got result %h expected none", i, sw_r[i]);
          else begin
            e = swq[i].pop_front();
            if ({sw_of[i], sw_co[i], sw_r[i]} !== e)
              $display("FAIL sweep_result[%0d]: got %h expected %h", i, {sw_of[i], sw_co[i], sw_r[i]}, e);
            else pass_cnt++;
          end
        end
        if (sw_v[i] && sw_ir[i])
          swq[i].push_back(model(sw_w(i), sw_a[i], sw_b[i], sw_c[i], sw_s[i]));
      end
    end
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (swq[i].size() != 0) $display("FAIL sweep_drain[%0d]: got %0d pending expected 0", i, swq[i].size());
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      sw_a[i] = '0;
      sw_b[i] = '0;
    end
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timed out");
  end

endmodule
